// File: rtl/block_window_loader_pkg.sv
// Shared beatmap definitions: entry layout, window size and loader FSM states.
// Used by the window loader and the downstream position stage.
package block_window_loader_pkg;

    localparam int unsigned BW_NUM_SLOTS = 12;
    localparam int unsigned COORD_W      = 12;
    localparam int unsigned TIME_W       = 18;
    localparam int unsigned DIR_W        = 3;
    localparam int unsigned ID_W         = 8;
    localparam int unsigned BLK_CNT_W    = 9;
    localparam int unsigned ENTRY_W      = 2 * COORD_W + TIME_W + 1 + DIR_W;

    // Field order matches the beatmap memory word, so a word casts directly.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [TIME_W-1:0]  hit_time;
        logic               color;
        logic [DIR_W-1:0]   direction;
    } block_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } loader_state_e;

endpackage

// File: rtl/mem_read_tracker.sv
// Tracks outstanding beatmap-memory reads with a MEM_LATENCY-deep valid/ID
// shift register so each returning word can be tagged with its block ID.
//   clk_in, rst_in     : clock, async active-low reset
//   issue_in, id_in    : a read strobe is on the memory port this cycle, and its address
//   flush_in           : drop every outstanding read (takes priority over issue_in)
//   ret_valid_out      : mem_data_in carries a tracked read this cycle
//   ret_id_out         : block ID of that returning read
//   pending_c          : number of reads currently held in the shift register
module mem_read_tracker
    import block_window_loader_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    localparam int unsigned PEND_W     = $clog2(MEM_LATENCY + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              issue_in,
    input  logic [ID_W-1:0]   id_in,
    input  logic              flush_in,
    output logic              ret_valid_out,
    output logic [ID_W-1:0]   ret_id_out,
    output logic [PEND_W-1:0] pending_c
);

    logic            vld_q [MEM_LATENCY];
    logic            vld_d [MEM_LATENCY];
    logic [ID_W-1:0] id_q  [MEM_LATENCY];
    logic [ID_W-1:0] id_d  [MEM_LATENCY];

    // Shift one stage per cycle; a flush empties the whole pipe.
    always_comb begin
        vld_d[0] = issue_in;
        id_d[0]  = id_in;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
        if (flush_in) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                vld_d[i] = 1'b0;
                id_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                id_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                vld_q[i] <= vld_d[i];
                id_q[i]  <= id_d[i];
            end
        end
    end

    // Outstanding-read count used for window slot reservation.
    always_comb begin
        pending_c = '0;
        for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            pending_c = pending_c + PEND_W'(vld_q[i]);
        end
    end

    assign ret_valid_out = vld_q[MEM_LATENCY-1];
    assign ret_id_out    = id_q[MEM_LATENCY-1];

endmodule

// File: rtl/block_window_loader.sv
// Streams beatmap entries from memory into a time-ordered sliding window of
// NUM_SLOTS slots (slot 0 oldest), evicting entries whose time has passed.
//   clk_in, rst_in        : clock, async active-low reset
//   start_in              : begin a song (restarts from any state)
//   num_blocks_in         : beatmap entry count, sampled on start_in
//   curr_time_in          : current song time
//   mem_addr_out/mem_rd_out : memory read request (address = block ID)
//   mem_data_in           : memory word, valid MEM_LATENCY cycles after mem_rd_out
//   block_*_out           : window contents per slot, zero when unoccupied
//   block_valid_out       : slot occupied
//   curr_time_out         : curr_time_in delayed one cycle
//   ready_out / done_out  : window initially filled / song exhausted
module block_window_loader
    import block_window_loader_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = BW_NUM_SLOTS,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [BLK_CNT_W-1:0] num_blocks_in,
    input  logic [TIME_W-1:0]    curr_time_in,
    output logic [ID_W-1:0]      mem_addr_out,
    output logic                 mem_rd_out,
    input  logic [ENTRY_W-1:0]   mem_data_in,
    output logic [COORD_W-1:0]   block_x_out         [NUM_SLOTS],
    output logic [COORD_W-1:0]   block_y_out         [NUM_SLOTS],
    output logic [TIME_W-1:0]    block_time_out      [NUM_SLOTS],
    output logic                 block_color_out     [NUM_SLOTS],
    output logic [DIR_W-1:0]     block_direction_out [NUM_SLOTS],
    output logic [ID_W-1:0]      block_ID_out        [NUM_SLOTS],
    output logic                 block_valid_out     [NUM_SLOTS],
    output logic [TIME_W-1:0]    curr_time_out,
    output logic                 ready_out,
    output logic                 done_out
);

    localparam int unsigned CNT_W  = $clog2(NUM_SLOTS + 1);
    localparam int unsigned PEND_W = $clog2(MEM_LATENCY + 1);
    localparam int unsigned OCC_W  = $clog2(NUM_SLOTS + MEM_LATENCY + 2);

    loader_state_e        state_q, state_d;
    logic [BLK_CNT_W-1:0] next_addr_q, next_addr_d;
    logic [BLK_CNT_W-1:0] num_blocks_q, num_blocks_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 mem_rd_q, mem_rd_d;
    logic [ID_W-1:0]      mem_addr_q, mem_addr_d;
    logic [TIME_W-1:0]    curr_time_q, curr_time_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    block_entry_t         win_q     [NUM_SLOTS];
    block_entry_t         win_d     [NUM_SLOTS];
    logic [ID_W-1:0]      win_id_q  [NUM_SLOTS];
    logic [ID_W-1:0]      win_id_d  [NUM_SLOTS];
    logic                 win_vld_q [NUM_SLOTS];
    logic                 win_vld_d [NUM_SLOTS];

    logic                 ret_valid;
    logic [ID_W-1:0]      ret_id;
    logic [PEND_W-1:0]    pending_c;

    logic                 evict;
    logic                 issue;
    logic                 all_read;
    logic [OCC_W-1:0]     in_flight;
    logic [OCC_W-1:0]     occ;
    logic [CNT_W-1:0]     wr_idx;

    // Tracks the strobe actually on the port, so returns line up with mem_data_in.
    mem_read_tracker #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tracker (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .issue_in      (mem_rd_q),
        .id_in         (mem_addr_q),
        .flush_in      (start_in),
        .ret_valid_out (ret_valid),
        .ret_id_out    (ret_id),
        .pending_c     (pending_c)
    );

    // Next-state, read issue and window update.
    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        num_blocks_d = num_blocks_q;
        count_d      = count_q;
        mem_rd_d     = 1'b0;
        mem_addr_d   = '0;
        curr_time_d  = curr_time_in;
        win_d        = win_q;
        win_id_d     = win_id_q;
        win_vld_d    = win_vld_q;

        // Reads on the port but not yet in the tracker still hold a slot.
        in_flight = OCC_W'(pending_c) + OCC_W'(mem_rd_q);
        evict     = (state_q == RUN) && win_vld_q[0] &&
                    (win_q[0].hit_time <= curr_time_in);
        occ       = OCC_W'(count_q) + in_flight - OCC_W'(evict);
        issue     = ((state_q == LOAD) || (state_q == RUN)) &&
                    (next_addr_q < num_blocks_q) && (occ < OCC_W'(NUM_SLOTS));
        all_read  = (next_addr_q == num_blocks_q) && (in_flight == '0);
        wr_idx    = count_q - CNT_W'(evict);

        if (issue) begin
            mem_rd_d    = 1'b1;
            mem_addr_d  = ID_W'(next_addr_q);
            next_addr_d = next_addr_q + BLK_CNT_W'(1);
        end

        // Eviction shifts everything toward slot 0 and zeroes the top slot.
        if (evict) begin
            for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
                win_d[i]     = win_q[i+1];
                win_id_d[i]  = win_id_q[i+1];
                win_vld_d[i] = win_vld_q[i+1];
            end
            win_d[NUM_SLOTS-1]     = '0;
            win_id_d[NUM_SLOTS-1]  = '0;
            win_vld_d[NUM_SLOTS-1] = 1'b0;
        end

        // Returned entry goes to the tail of the (possibly shifted) window.
        if (ret_valid) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    win_d[i]     = block_entry_t'(mem_data_in);
                    win_id_d[i]  = ret_id;
                    win_vld_d[i] = 1'b1;
                end
            end
        end
        count_d = count_q - CNT_W'(evict) + CNT_W'(ret_valid);

        case (state_q)
            IDLE: ;
            LOAD: if ((count_q == CNT_W'(NUM_SLOTS)) || all_read) state_d = RUN;
            RUN:  if (all_read && (count_q == '0)) state_d = DONE;
            DONE: ;
            default: state_d = IDLE;
        endcase

        // A start pulse wins over everything, including a read issued this cycle.
        if (start_in) begin
            state_d      = LOAD;
            next_addr_d  = '0;
            num_blocks_d = num_blocks_in;
            count_d      = '0;
            mem_rd_d     = 1'b0;
            mem_addr_d   = '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                win_d[i]     = '0;
                win_id_d[i]  = '0;
                win_vld_d[i] = 1'b0;
            end
        end

        ready_d = (state_d == RUN) || (state_d == DONE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            next_addr_q  <= '0;
            num_blocks_q <= '0;
            count_q      <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            curr_time_q  <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                win_q[i]     <= '0;
                win_id_q[i]  <= '0;
                win_vld_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            num_blocks_q <= num_blocks_d;
            count_q      <= count_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            curr_time_q  <= curr_time_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                win_q[i]     <= win_d[i];
                win_id_q[i]  <= win_id_d[i];
                win_vld_q[i] <= win_vld_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot_out
        assign block_x_out[g]         = win_q[g].x;
        assign block_y_out[g]         = win_q[g].y;
        assign block_time_out[g]      = win_q[g].hit_time;
        assign block_color_out[g]     = win_q[g].color;
        assign block_direction_out[g] = win_q[g].direction;
        assign block_ID_out[g]        = win_id_q[g];
        assign block_valid_out[g]     = win_vld_q[g];
    end

    assign mem_addr_out  = mem_addr_q;
    assign mem_rd_out    = mem_rd_q;
    assign curr_time_out = curr_time_q;
    assign ready_out     = ready_q;
    assign done_out      = done_q;

endmodule

// File: tb/tb_block_window_loader.sv
// Self-checking bench for block_window_loader: table of song configurations
// plus hand sequences for eviction, restart, empty song and async reset.
module tb_block_window_loader;

    localparam int unsigned NS  = 12;
    localparam int unsigned LAT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0;
    logic [8:0]  num_blocks_in = '0;
    logic [17:0] curr_time_in = '0;
    logic [7:0]  mem_addr_out;
    logic        mem_rd_out;
    logic [45:0] mem_data_in;
    logic [11:0] block_x_out         [NS];
    logic [11:0] block_y_out         [NS];
    logic [17:0] block_time_out      [NS];
    logic        block_color_out     [NS];
    logic [2:0]  block_direction_out [NS];
    logic [7:0]  block_ID_out        [NS];
    logic        block_valid_out     [NS];
    logic [17:0] curr_time_out;
    logic        ready_out;
    logic        done_out;

    block_window_loader #(
        .NUM_SLOTS   (NS),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .start_in            (start_in),
        .num_blocks_in       (num_blocks_in),
        .curr_time_in        (curr_time_in),
        .mem_addr_out        (mem_addr_out),
        .mem_rd_out          (mem_rd_out),
        .mem_data_in         (mem_data_in),
        .block_x_out         (block_x_out),
        .block_y_out         (block_y_out),
        .block_time_out      (block_time_out),
        .block_color_out     (block_color_out),
        .block_direction_out (block_direction_out),
        .block_ID_out        (block_ID_out),
        .block_valid_out     (block_valid_out),
        .curr_time_out       (curr_time_out),
        .ready_out           (ready_out),
        .done_out            (done_out)
    );

    always #5 clk_in = ~clk_in;

    // Beatmap contents: entry id has time 10*(id+1).
    function automatic logic [45:0] mem_word(int id);
        return {12'(id * 3 + 1), 12'(id + 100), 18'(10 * (id + 1)), 1'(id % 2), 3'(id % 8)};
    endfunction

    // Fixed-latency memory model.
    logic       rd_pipe [LAT];
    logic [7:0] ad_pipe [LAT];
    always @(posedge clk_in) begin
        rd_pipe[0] <= mem_rd_out;
        ad_pipe[0] <= mem_addr_out;
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            ad_pipe[i] <= ad_pipe[i-1];
        end
    end
    assign mem_data_in = rd_pipe[LAT-1] ? mem_word(int'(ad_pipe[LAT-1])) : {46{1'b1}};

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_addr_q[$];
    int rd_count = 0;
    int first_rd = -1;
    int last_rd = -1;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read scoreboard: every strobe must match the next expected address.
    always @(negedge clk_in) begin
        if (rst_in && mem_rd_out) begin
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (exp_addr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_read: got addr %0d, expected no read", mem_addr_out);
            end else begin
                chk("read_addr", 64'(mem_addr_out), 64'(exp_addr_q.pop_front()));
            end
        end
    end

    function automatic int valid_cnt();
        int n = 0;
        for (int i = 0; i < NS; i++) n += int'(block_valid_out[i]);
        return n;
    endfunction

    function automatic logic [63:0] slot_act(int i);
        return {9'd0, block_valid_out[i], block_ID_out[i], block_x_out[i], block_y_out[i],
                block_time_out[i], block_color_out[i], block_direction_out[i]};
    endfunction

    function automatic logic [63:0] slot_exp(int i, int cnt);
        if (i < cnt) return {9'd0, 1'b1, 8'(i), mem_word(i)};
        return 64'd0;
    endfunction

    typedef struct {
        int nb;
        int ct;
        int exp_reads;
        int exp_count;
        bit exp_ready;
        bit exp_done;
        int exp_span;
    } vec_t;

    vec_t vecs [10];

    task automatic start_song(input int nb, input int ct, input int n_exp);
        exp_addr_q.delete();
        for (int a = 0; a < n_exp; a++) exp_addr_q.push_back(a);
        rd_count = 0;
        first_rd = -1;
        last_rd  = -1;
        num_blocks_in = 9'(nb);
        curr_time_in  = 18'(ct);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        start_song(v.nb, v.ct, v.exp_reads);
        repeat (40 + 3 * v.nb) @(negedge clk_in);
        chk($sformatf("v%0d_reads", idx), 64'(rd_count), 64'(v.exp_reads));
        chk($sformatf("v%0d_count", idx), 64'(valid_cnt()), 64'(v.exp_count));
        chk($sformatf("v%0d_ready", idx), 64'(ready_out), 64'(v.exp_ready));
        chk($sformatf("v%0d_done", idx), 64'(done_out), 64'(v.exp_done));
        chk($sformatf("v%0d_ctime", idx), 64'(curr_time_out), 64'(v.ct));
        chk($sformatf("v%0d_sb_left", idx), 64'(exp_addr_q.size()), 64'd0);
        if (v.exp_span >= 0)
            chk($sformatf("v%0d_rd_span", idx), 64'(last_rd - first_rd), 64'(v.exp_span));
        for (int i = 0; i < NS; i++)
            chk($sformatf("v%0d_slot%0d", idx, i), slot_act(i), slot_exp(i, v.exp_count));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        logic done_seen;

        //            nb   ct      reads cnt rdy done span
        vecs[0] = '{  5,   0,      5,    5,  1,  0,   4};
        vecs[1] = '{ 20,   0,      12,   12, 1,  0,   11};
        vecs[2] = '{ 12,   0,      12,   12, 1,  0,   11};
        vecs[3] = '{ 13,   0,      12,   12, 1,  0,   11};
        vecs[4] = '{  1,   0,      1,    1,  1,  0,   0};
        vecs[5] = '{  0,   0,      0,    0,  1,  1,   -1};
        vecs[6] = '{  3,   5000,   3,    0,  1,  1,   -1};
        vecs[7] = '{ 20,   5000,   20,   0,  1,  1,   -1};
        vecs[8] = '{256,   200000, 256,  0,  1,  1,   -1};
        vecs[9] = '{ 11,   0,      11,   11, 1,  0,   10};

        // Reset state
        curr_time_in = 18'd99;
        repeat (3) @(negedge clk_in);
        chk("rst_ready", 64'(ready_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_rd", 64'(mem_rd_out), 64'd0);
        chk("rst_addr", 64'(mem_addr_out), 64'd0);
        chk("rst_ctime", 64'(curr_time_out), 64'd0);
        for (int i = 0; i < NS; i++) chk($sformatf("rst_slot%0d", i), slot_act(i), 64'd0);

        // First cycle after release does nothing without start
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_ready", 64'(ready_out), 64'd0);
        chk("post_rst_rd", 64'(mem_rd_out), 64'd0);
        @(negedge clk_in);
        chk("post_rst_rd2", 64'(mem_rd_out), 64'd0);

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Eviction with same-cycle refill of ID 12
        start_song(20, 0, 12);
        repeat (30) @(negedge clk_in);
        chk("ev_pre_count", 64'(valid_cnt()), 64'd12);
        exp_addr_q.push_back(12);
        curr_time_in = 18'd10;
        @(negedge clk_in);
        chk("ev_slot0_id", 64'(block_ID_out[0]), 64'd1);
        chk("ev_count", 64'(valid_cnt()), 64'd11);
        chk("ev_rd", 64'(mem_rd_out), 64'd1);
        chk("ev_addr", 64'(mem_addr_out), 64'd12);
        @(negedge clk_in);
        chk("ev_single_id", 64'(block_ID_out[0]), 64'd1);
        chk("ev_single_count", 64'(valid_cnt()), 64'd11);
        @(negedge clk_in);
        chk("ev_not_yet", 64'(block_valid_out[11]), 64'd0);
        @(negedge clk_in);
        chk("ev_land_slot11", slot_act(11), {9'd0, 1'b1, 8'd12, mem_word(12)});
        chk("ev_land_time", 64'(block_time_out[11]), 64'd130);
        chk("ev_land_count", 64'(valid_cnt()), 64'd12);
        repeat (5) @(negedge clk_in);
        chk("ev_sb_left", 64'(exp_addr_q.size()), 64'd0);

        // Restart with two reads in flight
        start_song(20, 0, 2);
        for (int a = 0; a < 12; a++) exp_addr_q.push_back(a);
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rs_rd_at_restart", 64'(mem_rd_out), 64'd1);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        chk("rs_count0", 64'(valid_cnt()), 64'd0);
        chk("rs_ready0", 64'(ready_out), 64'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rs_stale_a", 64'(valid_cnt()), 64'd0);
        @(negedge clk_in);
        chk("rs_stale_b", 64'(valid_cnt()), 64'd0);
        @(negedge clk_in);
        chk("rs_first", slot_act(0), slot_exp(0, 12));
        repeat (30) @(negedge clk_in);
        for (int i = 0; i < NS; i++) chk($sformatf("rs_slot%0d", i), slot_act(i), slot_exp(i, 12));
        chk("rs_sb_left", 64'(exp_addr_q.size()), 64'd0);

        // Empty song reaches DONE within three cycles
        start_song(0, 0, 0);
        done_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            if (done_out) done_seen = 1'b1;
        end
        chk("nb0_done_by_3", 64'(done_seen), 64'd1);
        repeat (4) @(negedge clk_in);
        chk("nb0_reads", 64'(rd_count), 64'd0);

        // Asynchronous reset mid-RUN
        start_song(20, 5, 12);
        repeat (30) @(negedge clk_in);
        chk("ar_pre_ready", 64'(ready_out), 64'd1);
        #2 rst_in = 1'b0;
        #1;
        chk("ar_ready", 64'(ready_out), 64'd0);
        chk("ar_done", 64'(done_out), 64'd0);
        chk("ar_ctime", 64'(curr_time_out), 64'd0);
        chk("ar_rd", 64'(mem_rd_out), 64'd0);
        for (int i = 0; i < NS; i++) chk($sformatf("ar_slot%0d", i), slot_act(i), 64'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("ar_post_ready", 64'(ready_out), 64'd0);
        chk("ar_post_count", 64'(valid_cnt()), 64'd0);
        @(negedge clk_in);
        chk("ar_post_rd", 64'(mem_rd_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
